// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with field decode, control generation,
// flush/stall handling and optional load-use hazard detection.
// Build option: define IDEX_HAZARD_EN to enable load-use detection; without it
// the hazard term is tied low, so stall_out stays 0 and only flush makes bubbles.
module id_ex_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_instr,
  input  logic [15:0] id_RegData1,
  input  logic [15:0] id_RegData2,
  input  logic [15:0] id_pcs,
  input  logic        id_valid,
  input  logic        flush,
  input  logic        stall_in,
  output logic [15:0] ex_instr,
  output logic [15:0] ex_RegData1,
  output logic [15:0] ex_RegData2,
  output logic [15:0] ex_pcs,
  output logic        ex_valid,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic [3:0]  ex_rd,
  output logic [3:0]  ex_rs,
  output logic [3:0]  ex_rt,
  output logic        stall_out,
  output logic [7:0]  bubble_cnt
);

`ifdef IDEX_HAZARD_EN
  localparam bit HazardEn = 1'b1;
`else
  localparam bit HazardEn = 1'b0;
`endif

  logic [3:0] opcode;
  logic [3:0] id_rd;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic       reads_rs;
  logic       reads_rt;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       hazard_raw;
  logic       hazard;

  // Decode register fields, source usage and control bits of the ID-stage instruction
  always_comb begin
    opcode   = id_instr[15:12];
    id_rd    = id_instr[11:8];
    id_rs    = id_instr[7:4];
    id_rt    = id_instr[3:0];
    // SW stores rd-field register; LLB/LHB merge into the rd-field register
    if (opcode == 4'b1001 || opcode == 4'b1010 || opcode == 4'b1011)
      id_rt = id_instr[11:8];
    reads_rs  = ~opcode[3] || opcode == 4'b1000 || opcode == 4'b1001 ||
                opcode == 4'b1101;
    reads_rt  = ~opcode[3] || opcode == 4'b1001 || opcode == 4'b1010 ||
                opcode == 4'b1011;
    reg_write = id_valid && (~opcode[3] || opcode == 4'b1000 ||
                opcode == 4'b1010 || opcode == 4'b1011 || opcode == 4'b1110);
    mem_read  = id_valid && opcode == 4'b1000;
    mem_write = id_valid && opcode == 4'b1001;
  end

  // Load-use detection against the instruction currently in EX; $0 never hazards
  always_comb begin
    hazard_raw = id_valid && ex_valid && ex_MemRead && (ex_rd != 4'd0) &&
                 ((reads_rs && ex_rd == id_rs) || (reads_rt && ex_rd == id_rt));
    hazard     = HazardEn && hazard_raw;
    stall_out  = hazard && !stall_in && !flush;
  end

  // Pipeline register: rst > stall_in > flush/hazard bubble > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_instr    <= '0;
      ex_RegData1 <= '0;
      ex_RegData2 <= '0;
      ex_pcs      <= '0;
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_rd       <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      bubble_cnt  <= '0;
    end else if (stall_in) begin
      ex_instr    <= ex_instr;
    end else if (flush || hazard) begin
      ex_instr    <= '0;
      ex_RegData1 <= '0;
      ex_RegData2 <= '0;
      ex_pcs      <= '0;
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_rd       <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      if (bubble_cnt != 8'hFF)
        bubble_cnt <= bubble_cnt + 8'd1;
    end else begin
      ex_instr    <= id_instr;
      ex_RegData1 <= id_RegData1;
      ex_RegData2 <= id_RegData2;
      ex_pcs      <= id_pcs;
      ex_valid    <= id_valid;
      ex_RegWrite <= reg_write;
      ex_MemRead  <= mem_read;
      ex_MemWrite <= mem_write;
      ex_rd       <= id_rd;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed bench for id_ex_pipe; expectations follow the
// IDEX_HAZARD_EN build option.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_instr, id_RegData1, id_RegData2, id_pcs;
  logic        id_valid, flush, stall_in;
  logic [15:0] ex_instr, ex_RegData1, ex_RegData2, ex_pcs;
  logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic [3:0]  ex_rd, ex_rs, ex_rt;
  logic        stall_out;
  logic [7:0]  bubble_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_bub = 8'd0;

`ifdef IDEX_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst),
    .id_instr(id_instr), .id_RegData1(id_RegData1), .id_RegData2(id_RegData2),
    .id_pcs(id_pcs), .id_valid(id_valid), .flush(flush), .stall_in(stall_in),
    .ex_instr(ex_instr), .ex_RegData1(ex_RegData1), .ex_RegData2(ex_RegData2),
    .ex_pcs(ex_pcs), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .stall_out(stall_out), .bubble_cnt(bubble_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic v);
    id_instr = instr;
    id_valid = v;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    id_RegData1 = 16'hFFFF; id_RegData2 = 16'hFFFF; id_pcs = 16'hFFFF;
    drive(16'h1234, 1'b1);
    tick();
    exp_bub = 8'd0;
    checks++;
    if ({ex_instr, ex_RegData1, ex_RegData2, ex_pcs} !== 64'd0) begin
      failures++;
      $display("FAIL reset_data got %h %h %h %h want 0", ex_instr, ex_RegData1, ex_RegData2, ex_pcs);
    end
    checks++;
    if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rd, ex_rs, ex_rt} !== 16'd0) begin
      failures++;
      $display("FAIL reset_ctrl got v%b w%b r%b m%b rd%h rs%h rt%h want 0",
               ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_rd, ex_rs, ex_rt);
    end
    checks++;
    if (bubble_cnt !== 8'd0 || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt got cnt=%h stall=%b want 0 0", bubble_cnt, stall_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_capture;
    id_RegData1 = 16'hAAAA; id_RegData2 = 16'h5555; id_pcs = 16'h0010;
    drive(16'h0123, 1'b1);
    tick();
    checks++;
    if (ex_instr !== 16'h0123 || ex_rd !== 4'd1 || ex_rs !== 4'd2 || ex_rt !== 4'd3) begin
      failures++;
      $display("FAIL capture_fields got %h rd%h rs%h rt%h want 0123 1 2 3", ex_instr, ex_rd, ex_rs, ex_rt);
    end
    checks++;
    if (ex_RegData1 !== 16'hAAAA || ex_RegData2 !== 16'h5555 || ex_pcs !== 16'h0010) begin
      failures++;
      $display("FAIL capture_data got %h %h %h want aaaa 5555 0010", ex_RegData1, ex_RegData2, ex_pcs);
    end
    checks++;
    if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite} !== 4'b1100) begin
      failures++;
      $display("FAIL capture_ctrl got %b%b%b%b want 1100", ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite);
    end
  endtask

  task automatic test_decode;
    drive(16'h9A12, 1'b1);       // SW: rt from [11:8]
    tick();
    checks++;
    if (ex_rd !== 4'hA || ex_rs !== 4'h1 || ex_rt !== 4'hA ||
        {ex_RegWrite, ex_MemRead, ex_MemWrite} !== 3'b001) begin
      failures++;
      $display("FAIL decode_sw got rd%h rs%h rt%h w%b r%b m%b want a 1 a 001",
               ex_rd, ex_rs, ex_rt, ex_RegWrite, ex_MemRead, ex_MemWrite);
    end
    drive(16'hA7FF, 1'b1);       // LLB
    tick();
    checks++;
    if (ex_rt !== 4'h7 || ex_rs !== 4'hF || {ex_RegWrite, ex_MemRead, ex_MemWrite} !== 3'b100) begin
      failures++;
      $display("FAIL decode_llb got rs%h rt%h w%b r%b m%b want f 7 100",
               ex_rs, ex_rt, ex_RegWrite, ex_MemRead, ex_MemWrite);
    end
    drive(16'h8420, 1'b0);       // invalid LW: control forced low
    tick();
    checks++;
    if (ex_instr !== 16'h8420 || {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite} !== 4'b0000) begin
      failures++;
      $display("FAIL decode_invalid got %h v%b w%b r%b m%b want 8420 0000",
               ex_instr, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite);
    end
  endtask

  task automatic test_load_use;
    drive(16'h8420, 1'b1);       // LW r4
    tick();
    drive(16'h0543, 1'b1);       // reads r4
    checks++;
    if (stall_out !== HAZ) begin
      failures++;
      $display("FAIL loaduse_stall got %b want %b", stall_out, HAZ);
    end
    tick();
    if (HAZ) begin
      exp_bub++;
      checks++;
      if (ex_valid !== 1'b0 || ex_instr !== 16'h0 || bubble_cnt !== exp_bub || stall_out !== 1'b0) begin
        failures++;
        $display("FAIL loaduse_bubble got v%b %h cnt=%h stall=%b want 0 0000 %h 0",
                 ex_valid, ex_instr, bubble_cnt, stall_out, exp_bub);
      end
      tick();
    end
    checks++;
    if (ex_instr !== 16'h0543 || ex_valid !== 1'b1 || bubble_cnt !== exp_bub) begin
      failures++;
      $display("FAIL loaduse_capture got %h v%b cnt=%h want 0543 1 %h", ex_instr, ex_valid, bubble_cnt, exp_bub);
    end
    // Register $0 never hazards
    drive(16'h8020, 1'b1);
    tick();
    drive(16'h0100, 1'b1);
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL r0_no_hazard got %b want 0", stall_out);
    end
    tick();
    // SW reads r4 through its rt field
    drive(16'h8420, 1'b1);
    tick();
    drive(16'h9412, 1'b1);
    checks++;
    if (stall_out !== HAZ) begin
      failures++;
      $display("FAIL sw_rt_hazard got %b want %b", stall_out, HAZ);
    end
    // LLB's [7:4] is immediate, not a source
    drive(16'hA54F, 1'b1);
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL llb_imm_no_hazard got %b want 0", stall_out);
    end
    // Flush concurrent with hazard: one bubble, no stall
    drive(16'h0543, 1'b1);
    flush = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_hazard_stall got %b want 0", stall_out);
    end
    tick();
    flush = 1'b0;
    exp_bub++;
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== exp_bub || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_hazard_bubble got v%b cnt=%h stall=%b want 0 %h 0", ex_valid, bubble_cnt, stall_out, exp_bub);
    end
    tick();
    checks++;
    if (ex_instr !== 16'h0543 || bubble_cnt !== exp_bub) begin
      failures++;
      $display("FAIL flush_hazard_next got %h cnt=%h want 0543 %h", ex_instr, bubble_cnt, exp_bub);
    end
  endtask

  task automatic test_priority;
    drive(16'h0123, 1'b1);
    tick();
    stall_in = 1'b1; flush = 1'b1;
    drive(16'h1111, 1'b1);
    tick();
    checks++;
    if (ex_instr !== 16'h0123 || ex_valid !== 1'b1 || bubble_cnt !== exp_bub || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL stall_over_flush got %h v%b cnt=%h stall=%b want 0123 1 %h 0",
               ex_instr, ex_valid, bubble_cnt, stall_out, exp_bub);
    end
    stall_in = 1'b0;
    tick();
    flush = 1'b0;
    exp_bub++;
    checks++;
    if (ex_instr !== 16'h0 || ex_valid !== 1'b0 || bubble_cnt !== exp_bub) begin
      failures++;
      $display("FAIL flush_release got %h v%b cnt=%h want 0000 0 %h", ex_instr, ex_valid, bubble_cnt, exp_bub);
    end
    // Stall while a hazard is pending: hold, no stall_out
    drive(16'h8420, 1'b1);
    tick();
    stall_in = 1'b1;
    drive(16'h0543, 1'b1);
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL stall_masks_hazard got %b want 0", stall_out);
    end
    tick();
    checks++;
    if (ex_instr !== 16'h8420 || bubble_cnt !== exp_bub) begin
      failures++;
      $display("FAIL stall_hold got %h cnt=%h want 8420 %h", ex_instr, bubble_cnt, exp_bub);
    end
    // Reset mid-stall clears everything
    rst = 1'b1;
    tick();
    rst = 1'b0; stall_in = 1'b0;
    exp_bub = 8'd0;
    #1;
    checks++;
    if (ex_instr !== 16'h0 || ex_MemRead !== 1'b0 || bubble_cnt !== 8'd0 || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stall got %h r%b cnt=%h stall=%b want 0000 0 00 0",
               ex_instr, ex_MemRead, bubble_cnt, stall_out);
    end
  endtask

  task automatic test_saturation;
    flush = 1'b1;
    for (int unsigned i = 0; i < 260; i++) begin
      tick();
      if (exp_bub != 8'hFF) exp_bub++;
      if (i == 253 || i == 254 || i == 259) begin
        checks++;
        if (bubble_cnt !== exp_bub) begin
          failures++;
          $display("FAIL saturation_%0d got %h want %h", i, bubble_cnt, exp_bub);
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_in = 1'b0;
    id_instr = '0; id_valid = 1'b0; id_RegData1 = '0; id_RegData2 = '0; id_pcs = '0;
    @(negedge clk);
    test_reset();
    test_capture();
    test_decode();
    test_load_use();
    test_priority();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have inputs id_instr 16, id_RegData1 16, id_RegData2 16, id_pcs 16: decode-stage instruction, register-file read data and PC+2.
REQ-004 SHALL have inputs id_valid 1 (decode slot holds real instruction), flush 1 (taken branch squash), stall_in 1 (global freeze).
REQ-005 SHALL have outputs ex_instr 16, ex_RegData1 16, ex_RegData2 16, ex_pcs 16 feeding the EX operand-select stage.
REQ-006 SHALL have outputs ex_valid 1, ex_RegWrite 1, ex_MemRead 1, ex_MemWrite 1, ex_rd 4, ex_rs 4, ex_rt 4 (rs/rt consumed by forwarding logic).
REQ-007 SHALL have outputs stall_out 1 (combinational hold request to PC and IF/ID) and bubble_cnt 8.

Function
REQ-008 Field decode SHALL be: opcode=instr[15:12], rd=instr[11:8], rs=instr[7:4], rt=instr[3:0], except opcode 1001 (SW) and 1010/1011 (LLB/LHB) SHALL use instr[11:8] as second source rt.
REQ-009 RegWrite SHALL be 1 for opcodes 0xxx, 1000, 1010, 1011, 1110; MemRead SHALL be 1 only for 1000; MemWrite SHALL be 1 only for 1001; all three forced 0 when id_valid=0.
REQ-010 Per-edge priority SHALL be rst > stall_in > flush > hazard > capture.
REQ-011 Capture: all ex_* registers SHALL load decoded id_* values and ex_valid<=id_valid; latency exactly 1 cycle.
REQ-012 stall_in=1 SHALL hold every ex_* register and bubble_cnt unchanged; stall_out SHALL be 0 while stall_in=1.
REQ-013 Bubble (flush or hazard) SHALL load ex_instr, ex_RegData1/2, ex_pcs, ex_rd/rs/rt with 0 and ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite with 0.
REQ-014 Hazard SHALL be asserted when id_valid & ex_valid & ex_MemRead & ex_rd!=0 & (ex_rd==id rs or ex_rd==id rt, for sources the opcode actually reads).
REQ-015 stall_out SHALL equal hazard & ~stall_in & ~flush, same cycle, no registered delay.
REQ-016 A hazard SHALL produce exactly one bubble; the next cycle the stalled instruction SHALL be captured because ex_MemRead is then 0.
REQ-017 flush concurrent with hazard SHALL produce one bubble and stall_out=0.
REQ-018 bubble_cnt SHALL increment by 1 on every inserted bubble (flush or hazard), saturating at 8'hFF, never wrapping.
REQ-019 Register $0 SHALL never trigger a hazard.

Reset
REQ-020 On rst=1 at a rising edge all ex_* outputs and bubble_cnt SHALL become 0 regardless of stall_in, flush or hazard.
REQ-021 rst asserted mid-stall SHALL clear state; stall_out SHALL be 0 the cycle after reset since ex_valid=0.

Configuration
REQ-022 Macro IDEX_HAZARD_EN defined SHALL enable load-use detection per REQ-014..REQ-017.
REQ-023 Macro IDEX_HAZARD_EN undefined SHALL tie hazard to 0: stall_out constant 0, bubbles only from flush, all other behaviour unchanged.

Verification
REQ-024 Reset: rst=1 one edge with id_instr=16'h1234, id_valid=1 -> all ex_* = 0, bubble_cnt=0.
REQ-025 Capture: id_instr=16'h0123, RegData1=16'hAAAA, RegData2=16'h5555, id_valid=1 -> next edge ex_instr=16'h0123, ex_rd=1, ex_rs=2, ex_rt=3, ex_RegWrite=1, ex_RegData1=16'hAAAA.
REQ-026 Load-use (macro on): ex holds LW r4 (16'h8420), id_instr=16'h0543 -> stall_out=1, next edge bubble ex_valid=0, bubble_cnt=1; following edge ex_instr=16'h0543.
REQ-027 Same stimulus with macro off -> stall_out=0, ex_instr=16'h0543 after one edge, bubble_cnt=0.
REQ-028 Priority: stall_in=1 and flush=1 together -> ex_* held, bubble_cnt held; release stall_in with flush=1 -> bubble, bubble_cnt+1.
REQ-029 Saturation: 260 consecutive flush cycles -> bubble_cnt=8'hFF and remains 8'hFF.
